decoder: RTL and testbench



---
 rtl/decoder_pkg.sv | 25 ++
 rtl/decoder_bin2onehot.sv | 30 +++
 rtl/decoder.sv | 59 +++++
 tb/tb_decoder.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the binary-to-one-hot decoder.
//   KEY_W_DEF : default key width (2-to-4 decoder)
//   OUT_W_DEF : output width derived from the default key width
//   onehot()  : maps a key (up to KEY_W_MAX bits) to a one-hot word
package decoder_pkg;

  localparam int unsigned KEY_W_DEF = 2;
  localparam int unsigned OUT_W_DEF = 1 << KEY_W_DEF;

  // Widest supported key; onehot() works at this width and callers slice.
  localparam int unsigned KEY_W_MAX = 6;
  localparam int unsigned OUT_W_MAX = 1 << KEY_W_MAX;

  // Per-bit compare rather than a shift, so each output bit is an
  // independent equality term.
  function automatic logic [OUT_W_MAX-1:0] onehot(input logic [KEY_W_MAX-1:0] key);
    logic [OUT_W_MAX-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < OUT_W_MAX; i++) begin
      res[i] = (key == KEY_W_MAX'(i));
    end
    return res;
  endfunction

endpackage : decoder_pkg

// File: rtl/decoder_bin2onehot.sv
// Combinational binary-to-one-hot conversion with an enable gate.
//   key_i    : binary select code, KEY_W bits (1..6)
//   en_i     : enable; when low the output is forced to zero
//   onehot_o : 2**KEY_W-bit one-hot word (all zero when disabled)
module bin2onehot
  import decoder_pkg::*;
#(
  parameter int unsigned KEY_W = KEY_W_DEF
) (
  input  logic [KEY_W-1:0]         key_i,
  input  logic                     en_i,
  output logic [(1 << KEY_W)-1:0]  onehot_o
);

  localparam int unsigned OUT_W = 1 << KEY_W;

  logic [OUT_W_MAX-1:0] full_c;

  assign full_c = onehot(KEY_W_MAX'(key_i));

  // Explicit enable gate: an unknown key while disabled never reaches the output.
  assign onehot_o = en_i ? full_c[OUT_W-1:0] : '0;

  // Upper bits of the max-width decode are not needed for narrow keys.
  if (OUT_W < OUT_W_MAX) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^full_c[OUT_W_MAX-1:OUT_W];
  end

endmodule : bin2onehot

// File: rtl/decoder.sv
// Registered binary-to-one-hot decoder with enable and optional one-cold output.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset (priority over En/key)
//   key : binary select code, KEY_W bits (1..6)
//   En  : decode enable, active high
//   opt : registered one-hot decode (inverted when ACTIVE_LOW=1)
//   vld : registered copy of En; never inverted
module decoder
  import decoder_pkg::*;
#(
  parameter int unsigned KEY_W      = KEY_W_DEF,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [KEY_W-1:0]         key,
  input  logic                     En,
  output logic [(1 << KEY_W)-1:0]  opt,
  output logic                     vld
);

  localparam int unsigned OUT_W = 1 << KEY_W;

  // Pattern presented when no line is selected (all 0s, or all 1s for one-cold).
  localparam logic [OUT_W-1:0] IDLE_PAT = {OUT_W{ACTIVE_LOW}};

  logic [OUT_W-1:0] dec_c;
  logic [OUT_W-1:0] opt_d, opt_q;
  logic             vld_d, vld_q;

  bin2onehot #(
    .KEY_W    (KEY_W)
  ) u_bin2onehot (
    .key_i    (key),
    .en_i     (En),
    .onehot_o (dec_c)
  );

  // Next-state: polarity applied before the register so the output is glitch-free.
  always_comb begin
    opt_d = dec_c ^ IDLE_PAT;
    vld_d = En;
  end

  // Output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      opt_q <= IDLE_PAT;
      vld_q <= 1'b0;
    end else begin
      opt_q <= opt_d;
      vld_q <= vld_d;
    end
  end

  assign opt = opt_q;
  assign vld = vld_q;

endmodule : decoder

// File: tb/tb_decoder.sv
// Scoreboard bench: stimulus pushes expected outputs, monitor pops and compares.
module tb_decoder;

  typedef struct {
    logic [7:0] opt;
    logic       vld;
    string      name;
  } exp_t;

  logic       clk;
  // Instance A: default 2-to-4, active-high
  logic       rst_a, en_a;
  logic [1:0] key_a;
  logic [3:0] opt_a;
  logic       vld_a;
  // Instance B: 3-to-8, active-low
  logic       rst_b, en_b;
  logic [2:0] key_b;
  logic [7:0] opt_b;
  logic       vld_b;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  int total = 0;
  int bad   = 0;

  decoder u_dut_a (
    .clk (clk), .rst (rst_a), .key (key_a), .En (en_a),
    .opt (opt_a), .vld (vld_a)
  );

  decoder #(.KEY_W(3), .ACTIVE_LOW(1'b1)) u_dut_b (
    .clk (clk), .rst (rst_b), .key (key_b), .En (en_b),
    .opt (opt_b), .vld (vld_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_a(input logic r, input logic e, input logic [1:0] k,
                         input logic [3:0] eo, input logic ev, input string nm);
    exp_t x;
    @(negedge clk);
    rst_a = r; en_a = e; key_a = k;
    x.opt = {4'b0000, eo}; x.vld = ev; x.name = nm;
    q_a.push_back(x);
  endtask

  task automatic drive_b(input logic r, input logic e, input logic [2:0] k,
                         input logic [7:0] eo, input logic ev, input string nm);
    exp_t x;
    @(negedge clk);
    rst_b = r; en_b = e; key_b = k;
    x.opt = eo; x.vld = ev; x.name = nm;
    q_b.push_back(x);
  endtask

  // Monitor: every edge the DUT presents a fresh registered output.
  always @(posedge clk) begin
    #1;
    if (q_a.size() > 0) begin
      e_a = q_a.pop_front();
      total++;
      if (opt_a !== e_a.opt[3:0] || vld_a !== e_a.vld) begin
        bad++;
        $display("FAIL %s: got opt=%b vld=%b, want opt=%b vld=%b",
                 e_a.name, opt_a, vld_a, e_a.opt[3:0], e_a.vld);
      end
    end
    if (q_b.size() > 0) begin
      e_b = q_b.pop_front();
      total++;
      if (opt_b !== e_b.opt || vld_b !== e_b.vld) begin
        bad++;
        $display("FAIL %s: got opt=%b vld=%b, want opt=%b vld=%b",
                 e_b.name, opt_b, vld_b, e_b.opt, e_b.vld);
      end
    end
  end

  initial begin
    logic [1:0] kx;
    rst_a = 1'b1; en_a = 1'b0; key_a = 2'b00;
    rst_b = 1'b1; en_b = 1'b0; key_b = 3'd0;

    // Reset for two cycles, then release with En low
    drive_a(1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, "a_reset0");
    drive_a(1'b1, 1'b1, 2'b11, 4'b0000, 1'b0, "a_reset1_prio");
    drive_a(1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, "a_idle");

    // Enabled sweep
    drive_a(1'b0, 1'b1, 2'b00, 4'b0001, 1'b1, "a_en_k0");
    drive_a(1'b0, 1'b1, 2'b01, 4'b0010, 1'b1, "a_en_k1");
    drive_a(1'b0, 1'b1, 2'b10, 4'b0100, 1'b1, "a_en_k2");
    drive_a(1'b0, 1'b1, 2'b11, 4'b1000, 1'b1, "a_en_k3");

    // Disabled sweep, key ignored
    drive_a(1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, "a_dis_k0");
    drive_a(1'b0, 1'b0, 2'b01, 4'b0000, 1'b0, "a_dis_k1");
    drive_a(1'b0, 1'b0, 2'b10, 4'b0000, 1'b0, "a_dis_k2");
    drive_a(1'b0, 1'b0, 2'b11, 4'b0000, 1'b0, "a_dis_k3");
    kx = 2'bxx;
    drive_a(1'b0, 1'b0, kx, 4'b0000, 1'b0, "a_dis_kx");

    // Reset mid-operation with En held high
    drive_a(1'b0, 1'b1, 2'b10, 4'b0100, 1'b1, "a_hold_k2");
    drive_a(1'b1, 1'b1, 2'b10, 4'b0000, 1'b0, "a_mid_reset");
    drive_a(1'b0, 1'b1, 2'b10, 4'b0100, 1'b1, "a_after_reset");

    // En falls on the same cycle key changes: 1000 must never appear
    drive_a(1'b0, 1'b1, 2'b01, 4'b0010, 1'b1, "a_tog_k1");
    drive_a(1'b0, 1'b0, 2'b11, 4'b0000, 1'b0, "a_tog_fall");
    drive_a(1'b0, 1'b0, 2'b11, 4'b0000, 1'b0, "a_tog_after");

    // Active-low 3-to-8 instance
    drive_b(1'b1, 1'b1, 3'd5, 8'hFF, 1'b0, "b_reset");
    drive_b(1'b0, 1'b0, 3'd5, 8'hFF, 1'b0, "b_idle");
    drive_b(1'b0, 1'b1, 3'd5, 8'b1101_1111, 1'b1, "b_en_k5");
    drive_b(1'b0, 1'b1, 3'd0, 8'b1111_1110, 1'b1, "b_en_k0");
    drive_b(1'b0, 1'b1, 3'd7, 8'b0111_1111, 1'b1, "b_en_k7");
    drive_b(1'b0, 1'b0, 3'd3, 8'hFF, 1'b0, "b_dis");
    drive_b(1'b1, 1'b1, 3'd2, 8'hFF, 1'b0, "b_mid_reset");

    // Drain with a bounded wait
    for (int i = 0; i < 5 && (q_a.size() > 0 || q_b.size() > 0); i++) begin
      @(posedge clk);
      #2;
    end
    if (q_a.size() > 0 || q_b.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending a=%0d b=%0d, want 0", q_a.size(), q_b.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_decoder
